// File: rtl/ws2812b_pkg.sv
// Shared constants and FSM state type for the 8x8 WS2812B matrix driver.
package ws2812b_pkg;
    localparam int NUM_ROWS   = 8;
    localparam int ROW_BITS   = 192;
    localparam int FRAME_BITS = NUM_ROWS * ROW_BITS;

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_LOAD = 2'd1,
        ST_BIT  = 2'd2
    } state_e;
endpackage

// File: rtl/ws2812b_bit_encoder.sv
// Maps one data bit and its position within the bit slot to the WS2812B line level.
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
#(
    parameter int T0H   = 20,
    parameter int T1H   = 40,
    parameter int CNT_W = 14
) (
    input  logic             bit_i,
    input  logic [CNT_W-1:0] slot_cnt_i,
    output logic             level_o
);
    // High for the first T0H/T1H cycles of the slot, low for the rest.
    assign level_o = bit_i ? (slot_cnt_i < CNT_W'(T1H)) : (slot_cnt_i < CNT_W'(T0H));
endmodule

// File: rtl/rgb_ws2812b_64_driver.sv
// Continuously streams a 1536-bit GRB frame (8 rows x 8 LEDs) onto a WS2812B line,
// separated by a low latch gap; an external-active request releases the line.
module rgb_ws2812b_64_driver
    import ws2812b_pkg::*;
#(
    parameter int T_BIT = 63,
    parameter int T0H   = 20,
    parameter int T1H   = 40,
    parameter int T_RST = 15000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [0:191] rgb_data_01,
    input  logic [0:191] rgb_data_02,
    input  logic [0:191] rgb_data_03,
    input  logic [0:191] rgb_data_04,
    input  logic [0:191] rgb_data_05,
    input  logic [0:191] rgb_data_06,
    input  logic [0:191] rgb_data_07,
    input  logic [0:191] rgb_data_08,
    input  logic         rgb_ext_activ,
    output logic         out
);
    localparam int CNT_MAX = (T_RST > T_BIT) ? T_RST : T_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(T_BIT - 1);
    localparam logic [10:0]      BIT_LAST  = 11'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [10:0]             bit_q, bit_d;
    logic [0:FRAME_BITS-1]   frame_q, frame_d;
    logic                    out_q, out_d;
    logic                    level;

    // The frame register shifts toward index 0, so the current bit is always frame_q[0].
    ws2812b_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .CNT_W(CNT_W)
    ) u_enc (
        .bit_i     (frame_q[0]),
        .slot_cnt_i(cnt_q),
        .level_o   (level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        out_d   = 1'b0;
        if (rgb_ext_activ) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    frame_d = {rgb_data_01, rgb_data_02, rgb_data_03, rgb_data_04,
                               rgb_data_05, rgb_data_06, rgb_data_07, rgb_data_08};
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_BIT;
                end
                ST_BIT: begin
                    out_d = level;
                    if (cnt_q == SLOT_LAST) begin
                        cnt_d   = '0;
                        frame_d = frame_q << 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_GAP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_GAP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: tb/tb_rgb_ws2812b_64_driver.sv
// Directed bench for the WS2812B matrix driver using shortened slot/gap timing.
module tb_rgb_ws2812b_64_driver;
    localparam int T_BIT = 5;
    localparam int T0H   = 1;
    localparam int T1H   = 3;
    localparam int T_RST = 20;
    localparam int LIMIT = 20000;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         ext     = 1'b0;
    logic [0:191] d1, d2, d3, d4, d5, d6, d7, d8;
    logic         out;

    int checks = 0;
    int passes = 0;
    logic [0:1535] got, exp;
    int bad, lows, ones;

    rgb_ws2812b_64_driver #(
        .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RST(T_RST)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rgb_data_01  (d1),
        .rgb_data_02  (d2),
        .rgb_data_03  (d3),
        .rgb_data_04  (d4),
        .rgb_data_05  (d5),
        .rgb_data_06  (d6),
        .rgb_data_07  (d7),
        .rgb_data_08  (d8),
        .rgb_ext_activ(ext),
        .out          (out)
    );

    always #5 clk = ~clk;

    task automatic set_all(input logic [0:191] v);
        d1 = v; d2 = v; d3 = v; d4 = v; d5 = v; d6 = v; d7 = v; d8 = v;
    endtask

    function automatic logic [0:1535] frame_of();
        return {d1, d2, d3, d4, d5, d6, d7, d8};
    endfunction

    // Counts low samples until out is seen high; returns with the first high sample current.
    task automatic wait_rise(output int n);
        n = 0;
        @(negedge clk);
        while (out !== 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Decodes 1536 slots starting at the current (first high) sample.
    task automatic decode_frame(input int chg_slot, input logic [0:191] chg_val,
                                output logic [0:1535] bits, output int nbad);
        nbad = 0;
        bits = '0;
        for (int s = 0; s < 1536; s++) begin
            int h;
            bit seen0;
            h = 0;
            seen0 = 1'b0;
            for (int c = 0; c < T_BIT; c++) begin
                if (!(s == 0 && c == 0)) @(negedge clk);
                if (s == chg_slot && c == 0) d3 = chg_val;
                if (out === 1'b1) begin
                    if (seen0) nbad++;
                    else h++;
                end else begin
                    seen0 = 1'b1;
                end
            end
            if (h == T1H) bits[s] = 1'b1;
            else if (h != T0H) nbad++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ext = 1'b0;
        set_all(192'd2);
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 1'b0) $display("FAIL reset_out: got %b expected 0", out); else passes++;
        reset_n = 1'b1;
        wait_rise(lows);
        checks++;
        if (lows != T_RST + 1) $display("FAIL reset_gap: got %0d expected %0d", lows, T_RST + 1); else passes++;
        exp = frame_of();
        decode_frame(-1, '0, got, bad);
        checks++;
        if (bad != 0) $display("FAIL two_shape: got %0d bad slots expected 0", bad); else passes++;
        checks++;
        if ($countones(got) != 8) $display("FAIL two_ones: got %0d expected 8", $countones(got)); else passes++;
        checks++;
        if (got[190] !== 1'b1 || got[191] !== 1'b0)
            $display("FAIL two_pos: got bits190/191=%b%b expected 10", got[190], got[191]);
        else passes++;
        checks++;
        if (got !== exp) $display("FAIL two_frame: got %0d ones expected %0d (content differs)", $countones(got), $countones(exp)); else passes++;
    endtask

    task automatic test_row1_ones();
        set_all('0);
        d1 = '1;
        wait_rise(lows);
        checks++;
        if (lows != T_RST + 1) $display("FAIL period_gap: got %0d expected %0d", lows, T_RST + 1); else passes++;
        decode_frame(-1, '0, got, bad);
        checks++;
        if (bad != 0) $display("FAIL row1_shape: got %0d bad slots expected 0", bad); else passes++;
        checks++;
        if ($countones(got[0:191]) != 192 || $countones(got) != 192)
            $display("FAIL row1_ones: got %0d/%0d expected 192/192", $countones(got[0:191]), $countones(got));
        else passes++;
    endtask

    task automatic test_midframe_change();
        logic [0:191] a, b;
        logic [0:1535] exp2;
        a = {24{8'h3C}};
        b = {24{8'hC3}};
        set_all('0);
        d1 = 192'hFFFF;
        d3 = a;
        wait_rise(lows);
        exp = frame_of();
        decode_frame(96, b, got, bad);
        checks++;
        if ($countones(got) != 112) $display("FAIL mid_old_ones: got %0d expected 112", $countones(got)); else passes++;
        checks++;
        if (got !== exp || bad != 0) $display("FAIL mid_old_frame: got %0d ones, %0d bad, expected %0d ones", $countones(got), bad, $countones(exp)); else passes++;
        exp2 = frame_of();
        wait_rise(lows);
        decode_frame(-1, '0, got, bad);
        checks++;
        if (got[384:391] !== 8'hC3) $display("FAIL mid_new_row3: got %h expected c3", got[384:391]); else passes++;
        checks++;
        if (got !== exp2 || bad != 0) $display("FAIL mid_new_frame: got %0d ones, %0d bad, expected %0d ones", $countones(got), bad, $countones(exp2)); else passes++;
    endtask

    task automatic test_ext_activ();
        set_all('1);
        wait_rise(lows);
        checks++;
        if (lows != T_RST + 1) $display("FAIL ext_pre_gap: got %0d expected %0d", lows, T_RST + 1); else passes++;
        repeat (500 * T_BIT) @(negedge clk);
        checks++;
        if (out !== 1'b1) $display("FAIL ext_bit500_high: got %b expected 1", out); else passes++;
        ext = 1'b1;
        @(negedge clk);
        checks++;
        if (out !== 1'b0) $display("FAIL ext_release: got %b expected 0", out); else passes++;
        ones = 0;
        repeat (9) begin
            @(negedge clk);
            if (out !== 1'b0) ones++;
        end
        checks++;
        if (ones != 0) $display("FAIL ext_hold: got %0d high cycles expected 0", ones); else passes++;
        ext = 1'b0;
        wait_rise(lows);
        checks++;
        if (lows != T_RST + 1) $display("FAIL ext_gap: got %0d expected %0d", lows, T_RST + 1); else passes++;
        decode_frame(-1, '0, got, bad);
        checks++;
        if ($countones(got) != 1536 || bad != 0) $display("FAIL ext_frame: got %0d ones, %0d bad, expected 1536, 0", $countones(got), bad); else passes++;
    endtask

    task automatic test_reset_midframe();
        wait_rise(lows);
        repeat (100 * T_BIT) @(negedge clk);
        checks++;
        if (out !== 1'b1) $display("FAIL rst_mid_high: got %b expected 1", out); else passes++;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== 1'b0) $display("FAIL rst_mid_low: got %b expected 0", out); else passes++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_rise(lows);
        checks++;
        if (lows != T_RST + 1) $display("FAIL rst_mid_gap: got %0d expected %0d", lows, T_RST + 1); else passes++;
        decode_frame(-1, '0, got, bad);
        checks++;
        if ($countones(got) != 1536 || bad != 0) $display("FAIL rst_mid_frame: got %0d ones, %0d bad, expected 1536, 0", $countones(got), bad); else passes++;
    endtask

    initial begin
        set_all('0);
        test_reset();
        test_row1_ones();
        test_midframe_change();
        test_ext_activ();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rgb_ws2812b_64_driver.md
RGB_WS2812B_64_DRIVER -- requirements
Module: rgb_ws2812b_64_driver

Interface
REQ-001 Parameter T_BIT, default 63: clock cycles per WS2812B bit slot (1.26 us at 50 MHz).
REQ-002 Parameter T0H, default 20: high-time cycles for a '0' bit (0.40 us).
REQ-003 Parameter T1H, default 40: high-time cycles for a '1' bit (0.80 us).
REQ-004 Parameter T_RST, default 15000: low latch/reset-gap cycles between frames (300 us).
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock, rising-edge active.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 rgb_data_01 .. rgb_data_08  input  [0:191] each  pixel data for rows 1..8; 8 LEDs x 24 bits per row, GRB per LED; index 0 is MSB and is sent first.
REQ-009 rgb_ext_activ  input  1  external-active request; 1 = driver releases the line (out held 0) and frame is aborted.
REQ-010 out  output  1  WS2812B serial data line, registered.

Function
REQ-011 Frame: 1536 bits, sent in order rgb_data_01[0..191], then rgb_data_02[0..191], ..., rgb_data_08[0..191].
REQ-012 FSM states: GAP, LOAD, BIT; GAP -> LOAD after T_RST cycles with out=0; LOAD -> BIT in 1 cycle; BIT -> GAP after bit 1535 completes.
REQ-013 LOAD: snapshot all eight 192-bit inputs into a 1536-bit frame register; input changes during BIT do not affect the frame in flight.
REQ-014 Each bit slot lasts exactly T_BIT cycles: out=1 for T0H (bit 0) or T1H (bit 1) cycles, then out=0 for the remainder.
REQ-015 Consecutive bit slots are contiguous, with no idle cycles between them.
REQ-016 Frames repeat continuously; period = 1 + T_RST + 1536*T_BIT cycles (defaults: 111769).
REQ-017 rgb_ext_activ=1 in any state: next cycle out=0, FSM forced to GAP with gap counter cleared.
REQ-018 rgb_ext_activ held 1: FSM stays in GAP with counter cleared.
REQ-019 After rgb_ext_activ falls, a full T_RST low gap precedes the next LOAD.
REQ-020 Counters: cycle counter sized for max(T_RST, T_BIT); bit counter 11 bits (0..1535); no wrap beyond 1535.
REQ-021 Parameter legality: 0 < T0H < T1H < T_BIT; otherwise behaviour is undefined.

Reset
REQ-022 reset_n=0 at a rising edge: out=0, state=GAP, cycle and bit counters=0, frame register=0.
REQ-023 Reset mid-frame aborts the frame; the line stays low for at least T_RST cycles after reset_n rises.

Structure
REQ-024 Shared package ws2812b_pkg: NUM_ROWS=8, ROW_BITS=192, FRAME_BITS=1536, and the FSM state enum.
REQ-025 One sub-module, ws2812b_bit_encoder: takes bit value and slot-cycle count, produces the high/low pulse level; the top holds the FSM, counters and frame register.

Verification
REQ-026 Reset, then all rows = 192'd2, rgb_ext_activ=0 -> out low for 15001 cycles; then 190 '0' pulses (20 high / 43 low), one '1' pulse (40/23), one '0' pulse, repeated per row.
REQ-027 rgb_data_01 = all ones, other rows 0 -> first 192 slots show 40-cycle highs; the remaining 1344 slots show 20-cycle highs.
REQ-028 Change rgb_data_03 mid-frame during row 1 -> current frame unchanged; next frame carries the new value.
REQ-029 Assert rgb_ext_activ during bit 500 -> out=0 next cycle; deassert -> 15000 low cycles precede the next LOAD.
REQ-030 Assert reset_n=0 mid-frame for 3 cycles -> out=0 immediately; first rising edge of out occurs 15001 cycles after release.
REQ-031 Measure frame period with defaults -> 111769 cycles between successive LOAD states.
